// File: rtl/registers_32x32.sv
// registers_32x32: 2-read/1-write register file with sync clear; ZERO_REG_EN hardwires register 0 to zero
module registers_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0] readaddr1,
  input  logic [ADDR_W-1:0] readaddr2,
  input  logic [ADDR_W-1:0] writeaddr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_cntrl,
  input  logic              clk,
  input  logic              clr,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2
);
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  logic [DATA_W-1:0] regs [DEPTH];
  logic              we;
  assign we = write_cntrl && !(ZERO_REG && writeaddr == '0);
  // clear has priority over a write; writes to a hardwired zero register are dropped
  always_ff @(posedge clk)
    if (clr)
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (we)
      regs[writeaddr] <= write_data;
  // asynchronous reads of stored contents, no write bypass
  always_comb begin
    read1 = (ZERO_REG && readaddr1 == '0) ? '0 : regs[readaddr1];
    read2 = (ZERO_REG && readaddr2 == '0) ? '0 : regs[readaddr2];
  end
endmodule

// File: tb/tb_registers_32x32.sv
// tb_registers_32x32: directed self-checking bench for registers_32x32
module tb_registers_32x32;
  logic [4:0]  readaddr1, readaddr2, writeaddr;
  logic [31:0] write_data, read1, read2;
  logic        write_cntrl, clk, clr;
  int          total = 0, passed = 0;
`ifdef ZERO_REG_EN
  localparam logic [31:0] R0_EXP = 32'd0;
`else
  localparam logic [31:0] R0_EXP = 32'd5;
`endif

  registers_32x32 dut (
    .readaddr1(readaddr1), .readaddr2(readaddr2), .writeaddr(writeaddr),
    .write_data(write_data), .write_cntrl(write_cntrl), .clk(clk), .clr(clr),
    .read1(read1), .read2(read2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    writeaddr = a;
    write_data = d;
    write_cntrl = 1'b1;
    @(posedge clk);
    #1 write_cntrl = 1'b0;
  endtask

  initial begin
    logic [31:0] sum;
    clr = 1'b1; write_cntrl = 1'b0; writeaddr = '0; write_data = '0;
    readaddr1 = 5'd9; readaddr2 = 5'd9;
    @(posedge clk);
    #1 clr = 1'b0; readaddr1 = 5'd0; readaddr2 = 5'd0;
    #1 check("reset_r1", read1, 32'd0);
    check("reset_r2", read2, 32'd0);
    readaddr1 = 5'd31;
    #1 check("reset_r31", read1, 32'd0);

    wr(5'd25, 32'd25);
    readaddr1 = 5'd25;
    #1 check("wr25", read1, 32'd25);

    wr(5'd28, 32'd28);
    readaddr1 = 5'd28; readaddr2 = 5'd25;
    #1 check("dual_r1", read1, 32'd28);
    check("dual_r2", read2, 32'd25);
    sum = read1 + read2;
    wr(5'd16, sum);
    readaddr1 = 5'd16; readaddr2 = 5'd16;
    #1 check("wb16_r1", read1, 32'd53);
    check("wb16_r2_same", read2, 32'd53);

    wr(5'd31, 32'hDEADBEEF);
    wr(5'd30, 32'hFFFFFFFF);
    readaddr1 = 5'd31; readaddr2 = 5'd30;
    #1 check("full_w31", read1, 32'hDEADBEEF);
    check("full_w30", read2, 32'hFFFFFFFF);

    writeaddr = 5'd25; write_data = 32'd7; write_cntrl = 1'b0;
    @(posedge clk);
    #1 readaddr1 = 5'd25;
    #1 check("we_off", read1, 32'd25);

    readaddr1 = 5'd3; readaddr2 = 5'd3;
    writeaddr = 5'd3; write_data = 32'd9; write_cntrl = 1'b1;
    #1 check("nobypass_r1", read1, 32'd0);
    check("nobypass_r2", read2, 32'd0);
    @(posedge clk);
    #1 write_cntrl = 1'b0;
    check("after_edge_r1", read1, 32'd9);
    check("after_edge_r2", read2, 32'd9);

    writeaddr = 'x; write_data = 'x;
    @(posedge clk);
    #1 check("x_inputs_r3", read1, 32'd9);
    readaddr1 = 5'd25;
    #1 check("x_inputs_r25", read1, 32'd25);

    clr = 1'b1; write_cntrl = 1'b1; writeaddr = 5'd16; write_data = 32'd99;
    @(posedge clk);
    #1 clr = 1'b0; write_cntrl = 1'b0;
    readaddr1 = 5'd16; readaddr2 = 5'd25;
    #1 check("clr_wins16", read1, 32'd0);
    check("clr25", read2, 32'd0);

    wr(5'd5, 32'd77);
    readaddr1 = 5'd5;
    #1 clr = 1'b1;
    #2 check("clr_between_edges", read1, 32'd77);
    @(posedge clk);
    #1 clr = 1'b0;
    check("clr_at_edge", read1, 32'd0);

    clr = 1'b1; write_cntrl = 1'b1; writeaddr = 5'd7; write_data = 32'd11;
    readaddr1 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("clr_held", read1, 32'd0);
    end
    clr = 1'b0;
    @(posedge clk);
    #1 write_cntrl = 1'b0;
    check("resume_write", read1, 32'd11);

    wr(5'd0, 32'd5);
    readaddr1 = 5'd0; readaddr2 = 5'd0;
    #1 check("reg0_r1", read1, R0_EXP);
    check("reg0_r2", read2, R0_EXP);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/registers_32x32.md
REGISTERS_32X32 -- requirements
Module: registers_32x32

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32, register width in bits.
- ADDR_W, default 5, address width in bits.
- DEPTH, default 2**ADDR_W (32), number of registers.

REQ-002 Ports SHALL be:
- clk  input  1  single clock; all state changes occur on its rising edge.
- clr  input  1  reset, synchronous, active-high.
- readaddr1  input  ADDR_W  read port 1 address.
- readaddr2  input  ADDR_W  read port 2 address.
- writeaddr  input  ADDR_W  write port address.
- write_data  input  DATA_W  write port data.
- write_cntrl  input  1  write enable, active-high.
- read1  output  DATA_W  read port 1 data.
- read2  output  DATA_W  read port 2 data.

REQ-003 Port order SHALL be readaddr1, readaddr2, writeaddr, write_data, write_cntrl, clk, clr, read1, read2, so that positional instantiation works.

Function
REQ-004 Storage SHALL be DEPTH registers of DATA_W bits, plus two read ports and one write port.
REQ-005 read1 SHALL combinationally equal register[readaddr1], with zero-cycle latency and no clock dependency.
REQ-006 read2 SHALL behave like read1, using readaddr2.
REQ-007 On a rising clk edge with clr=0 and write_cntrl=1, register[writeaddr] SHALL load write_data; all other registers SHALL hold.
REQ-008 With write_cntrl=0, no register SHALL change, except by reset.
REQ-009 Write-to-read latency:
- A written value SHALL appear on a read port as soon as the register updates, i.e. in the same cycle after the edge.
- There SHALL be no write-to-read bypass: a read of writeaddr before the edge returns the old value.
REQ-010 Both read ports MAY address the same register, or the register being written, at the same time, with no conflict; each returns the stored value.
REQ-011 write_cntrl, writeaddr, write_data, readaddr1, readaddr2 SHALL be sampled or decoded only as described; X on an unused input SHALL not corrupt storage.
REQ-012 There SHALL be no arithmetic; data passes through unmodified at full DATA_W.

Reset
REQ-013 On a rising clk edge with clr=1, every register SHALL become 0, so read1 and read2 read 0 for any address after that edge.
REQ-014 clr SHALL have priority over a simultaneous write; the write is discarded.
REQ-015 clr held high for several cycles SHALL keep all registers at 0; normal writes resume on the first edge with clr=0.
REQ-016 clr asserted between edges SHALL have no effect until the next rising edge.

Configuration
REQ-017 Macro ZERO_REG_EN SHALL control register 0:
- Defined: register 0 is hardwired to 0; writes to address 0 are ignored, and read1/read2 return 0 for address 0.
- Undefined: register 0 is an ordinary writable register.

Verification
REQ-018 Reset check:
- Stimulus: clr=1 for one edge, then readaddr1=readaddr2=0.
- Response: read1=read2=0.

REQ-019 Basic write/read:
- Stimulus: write_cntrl=1, writeaddr=25, write_data=25, rising edge, then readaddr1=25.
- Response: read1=25.

REQ-020 Dual read and write-back:
- Stimulus: after writing 28 to address 28 and 25 to address 25, readaddr1=28 and readaddr2=25.
- Response: read1=28, read2=25.
- Stimulus: write read1+read2 to address 16, then read address 16.
- Response: read1=53.

REQ-021 Reset clears contents:
- Stimulus: with addresses 16 and 25 holding data, clr=1 for one edge.
- Response: read of 16 gives 0 and read of 25 gives 0; reset also wins over a concurrent write to 16.

REQ-022 Write enable and no bypass:
- Stimulus: write_cntrl=0 with writeaddr=25, write_data=7, rising edge.
- Response: address 25 is unchanged.
- Stimulus: set up a write of 9 to address 3 while readaddr1=3.
- Response: read1 shows the old value before the edge and 9 after it.

REQ-023 Register 0 with ZERO_REG_EN:
- Stimulus: with ZERO_REG_EN defined, write 5 to address 0.
- Response: read gives 0.
- Stimulus: the same write without the macro.
- Response: read gives 5.
